// File: rtl/layer_scroll_ctrl_pkg.sv
// Shared constants, types and helpers for the ground-layer scroll sequencer.
package layer_scroll_ctrl_pkg;

    // Width of one play-field row (one bit per column).
    localparam int unsigned LAYER_W           = 7;
    // Default scroll length in ms ticks; equals the layer height in pixels.
    localparam int unsigned SCROLL_MS_DEFAULT = 150;
    // Width of the completed-scroll counter.
    localparam int unsigned COUNT_W           = 16;

    typedef logic [0:LAYER_W-1] row_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_SCROLL = 3'd4,
        S_SETTLE = 3'd5,
        S_DONE   = 3'd6
    } scroll_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/layer_scroll_ctrl_if.sv
// Row-fetch handshake between the scroll sequencer and the map generator.
interface layer_scroll_ctrl_if;
    import layer_scroll_ctrl_pkg::*;

    logic gen_req;
    logic gen_valid;
    row_t gen_map;
    row_t gen_type;

    // Sequencer side: requests a row, receives it.
    modport master (
        output gen_req,
        input  gen_valid,
        input  gen_map,
        input  gen_type
    );

    // Generator side: sees the request, returns a row.
    modport slave (
        input  gen_req,
        output gen_valid,
        output gen_map,
        output gen_type
    );

endinterface

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms tick divider with a synchronous clear.
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 65000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_q;

    // Count 0..TICK_DIV-1 and wrap; clr restarts the period at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (clr || div_q == LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Decoded from the counter register only, so no input-to-output path.
    assign tick = (div_q == LAST);

endmodule

// File: rtl/layer_scroll_ctrl.sv
// Sequencer for the stacked scrolling ground layers: fetches a new top row,
// broadcasts load/start to the layer chain, times the scroll and reports done.
module layer_scroll_ctrl
    import layer_scroll_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 65_000_000,
    parameter int unsigned SCROLL_MS = SCROLL_MS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   scroll_req,
    layer_scroll_ctrl_if.master    gen,
    output row_t                   top_map,
    output row_t                   top_type,
    output logic                   layer_load,
    output logic                   layer_start,
    output logic                   one_ms_tick,
    output logic                   busy,
    output logic                   scroll_done,
    output logic                   req_overflow,
    output logic [COUNT_W-1:0]     scroll_count
);

    localparam int unsigned TICK_DIV  = CLK_HZ / 1000;
    localparam logic [7:0]  TICK_LAST = 8'(SCROLL_MS - 1);

    scroll_state_e      state_q;
    logic               pending_q;
    logic               gen_req_q;
    logic               load_q;
    logic               start_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic [7:0]         tick_cnt_q;
    logic               settle_q;
    logic [COUNT_W-1:0] count_q;
    row_t               top_map_q;
    row_t               top_type_q;
    logic               consume;

    // Divider is restarted during the start cycle so ticks line up with the layers.
    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_q),
        .tick  (one_ms_tick)
    );

    // A queued request is taken whenever the FSM is about to launch a new fetch.
    assign consume = pending_q && (state_q == S_IDLE || state_q == S_DONE);

    // Sequencer FSM, pending buffer and counters; every output is a flop here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            gen_req_q  <= 1'b0;
            load_q     <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            tick_cnt_q <= '0;
            settle_q   <= 1'b0;
            count_q    <= '0;
            top_map_q  <= '0;
            top_type_q <= '0;
        end else begin
            load_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;

            // One-deep request buffer; a request arriving alongside a consumed
            // pending one takes its place rather than being dropped.
            if (!en) begin
                pending_q <= 1'b0;
            end else if (consume) begin
                pending_q <= scroll_req;
            end else if (scroll_req && state_q != S_IDLE) begin
                if (pending_q) begin
                    ovf_q <= 1'b1;
                end else begin
                    pending_q <= 1'b1;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (en && (scroll_req || pending_q)) begin
                        state_q   <= S_FETCH;
                        gen_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // Nothing has reached the layers yet, so an abort is safe here.
                    if (!en) begin
                        state_q   <= S_IDLE;
                        gen_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (gen.gen_valid) begin
                        top_map_q  <= gen.gen_map;
                        top_type_q <= gen.gen_type;
                        gen_req_q  <= 1'b0;
                        load_q     <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    tick_cnt_q <= '0;
                    state_q    <= S_SCROLL;
                end
                S_SCROLL: begin
                    if (one_ms_tick) begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                        if (tick_cnt_q == TICK_LAST) begin
                            settle_q <= 1'b0;
                            state_q  <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    // Two cycles for the layers to walk through their end state.
                    if (settle_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        settle_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    count_q <= sat_inc(count_q);
                    if (en && pending_q) begin
                        gen_req_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    gen_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign gen.gen_req   = gen_req_q;
    assign top_map       = top_map_q;
    assign top_type      = top_type_q;
    assign layer_load    = load_q;
    assign layer_start   = start_q;
    assign busy          = busy_q;
    assign scroll_done   = done_q;
    assign req_overflow  = ovf_q;
    assign scroll_count  = count_q;

endmodule

// File: tb/tb_layer_scroll_ctrl.sv
// Self-checking bench for layer_scroll_ctrl: directed and randomized scroll
// sequences checked against a transaction-level timing model.
module tb_layer_scroll_ctrl;
    import layer_scroll_ctrl_pkg::*;

    localparam int CLK_HZ    = 10_000;
    localparam int SCROLL_MS = 3;
    localparam int TICK_DIV  = CLK_HZ / 1000;
    localparam int SPAN      = 5 + SCROLL_MS * TICK_DIV;  // gen_valid -> scroll_done
    localparam int MAXC      = 400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        scroll_req;
    row_t        top_map;
    row_t        top_type;
    logic        layer_load;
    logic        layer_start;
    logic        one_ms_tick;
    logic        busy;
    logic        scroll_done;
    logic        req_overflow;
    logic [15:0] scroll_count;

    layer_scroll_ctrl_if gif ();

    layer_scroll_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .SCROLL_MS (SCROLL_MS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .scroll_req   (scroll_req),
        .gen          (gif),
        .top_map      (top_map),
        .top_type     (top_type),
        .layer_load   (layer_load),
        .layer_start  (layer_start),
        .one_ms_tick  (one_ms_tick),
        .busy         (busy),
        .scroll_done  (scroll_done),
        .req_overflow (req_overflow),
        .scroll_count (scroll_count)
    );

    always #5 clk = ~clk;

    // One scroll as seen from outside: fetch starts at f, row accepted at k.
    // An aborted fetch has ab set and k is the cycle en was seen low.
    typedef struct {
        int f;
        int k;
        bit ab;
    } txn_t;

    txn_t tq[$];
    logic req_s [MAXC];
    logic val_s [MAXC];
    logic en_s  [MAXC];
    row_t map_s [MAXC];
    row_t typ_s [MAXC];
    logic ovf_e [MAXC];

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cur_t    = 0;
    row_t exp_map  = '0;
    row_t exp_type = '0;
    int   exp_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, cur_t, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int t = 0; t < MAXC; t++) begin
            req_s[t] = 1'b0;
            val_s[t] = 1'b0;
            en_s[t]  = 1'b1;
            map_s[t] = '0;
            typ_s[t] = '0;
            ovf_e[t] = 1'b0;
        end
        tq.delete();
    endtask

    task automatic add_txn(input int f, input int k, input bit ab);
        txn_t x;
        x.f  = f;
        x.k  = k;
        x.ab = ab;
        tq.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gen_req"}, 32'(gif.gen_req), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".load"}, 32'(layer_load), 0);
        check({tag, ".start"}, 32'(layer_start), 0);
        check({tag, ".done"}, 32'(scroll_done), 0);
        check({tag, ".ovf"}, 32'(req_overflow), 0);
        check({tag, ".tick"}, 32'(one_ms_tick), 0);
        check({tag, ".top_map"}, 32'(top_map), 0);
        check({tag, ".top_type"}, 32'(top_type), 0);
        check({tag, ".count"}, 32'(scroll_count), 0);
    endtask

    // Replay the stimulus tables for n cycles; each cycle first checks the
    // outputs against the model, then drives that cycle's inputs.
    task automatic run_seq(input string tag, input int n);
        logic e_req, e_busy, e_load, e_start, e_done, e_tick, chk_tick;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            cur_t    = t;
            e_req    = 1'b0;
            e_busy   = 1'b0;
            e_load   = 1'b0;
            e_start  = 1'b0;
            e_done   = 1'b0;
            e_tick   = 1'b0;
            chk_tick = 1'b0;
            foreach (tq[i]) begin
                if (t >= tq[i].f && t <= tq[i].k) e_req = 1'b1;
                if (tq[i].ab) begin
                    if (t >= tq[i].f && t <= tq[i].k) e_busy = 1'b1;
                end else begin
                    if (t >= tq[i].f && t <= tq[i].k + SPAN) e_busy = 1'b1;
                    if (t == tq[i].k + 1) begin
                        e_load   = 1'b1;
                        exp_map  = map_s[tq[i].k];
                        exp_type = typ_s[tq[i].k];
                    end
                    if (t == tq[i].k + 2) e_start = 1'b1;
                    if (t == tq[i].k + SPAN) e_done = 1'b1;
                    if (t == tq[i].k + SPAN + 1) exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
                    if (t >= tq[i].k + 3 && t <= tq[i].k + 2 + SCROLL_MS * TICK_DIV) begin
                        chk_tick = 1'b1;
                        e_tick   = ((t - tq[i].k - 2) % TICK_DIV) == 0;
                    end
                end
            end
            check({tag, ".gen_req"}, 32'(gif.gen_req), 32'(e_req));
            check({tag, ".busy"}, 32'(busy), 32'(e_busy));
            check({tag, ".load"}, 32'(layer_load), 32'(e_load));
            check({tag, ".start"}, 32'(layer_start), 32'(e_start));
            check({tag, ".done"}, 32'(scroll_done), 32'(e_done));
            check({tag, ".ovf"}, 32'(req_overflow), 32'(ovf_e[t]));
            check({tag, ".top_map"}, 32'(top_map), 32'(exp_map));
            check({tag, ".top_type"}, 32'(top_type), 32'(exp_type));
            check({tag, ".count"}, 32'(scroll_count), 32'(exp_cnt));
            if (chk_tick) check({tag, ".tick"}, 32'(one_ms_tick), 32'(e_tick));
            scroll_req   = req_s[t];
            gif.gen_valid = val_s[t];
            gif.gen_map  = map_s[t];
            gif.gen_type = typ_s[t];
            en           = en_s[t];
        end
        scroll_req    = 1'b0;
        gif.gen_valid = 1'b0;
        en            = 1'b1;
    endtask

    initial begin
        int s, k, d, last_k;
        rst_n         = 1'b0;
        en            = 1'b1;
        scroll_req    = 1'b0;
        gif.gen_valid = 1'b0;
        gif.gen_map   = '0;
        gif.gen_type  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Basic scroll, gen_valid held high the whole time
        clear_stim();
        req_s[0] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            val_s[t] = 1'b1;
            map_s[t] = 7'b1010101;
            typ_s[t] = 7'b0110011;
        end
        add_txn(1, 1, 1'b0);
        run_seq("basic", 40);

        // Slow generator plus a stray gen_valid during the scroll
        clear_stim();
        req_s[0] = 1'b1;
        val_s[6] = 1'b1;
        map_s[6] = 7'b1100110;
        typ_s[6] = 7'b0011001;
        val_s[20] = 1'b1;
        map_s[20] = 7'b1111111;
        typ_s[20] = 7'b1111111;
        add_txn(1, 6, 1'b0);
        run_seq("slow", 6 + SPAN + 3);

        // Queued request and two overflows
        clear_stim();
        req_s[0] = 1'b1;
        val_s[1] = 1'b1;
        map_s[1] = 7'b0001111;
        typ_s[1] = 7'b1110000;
        req_s[20] = 1'b1;
        req_s[25] = 1'b1;
        ovf_e[26] = 1'b1;
        req_s[30] = 1'b1;
        ovf_e[31] = 1'b1;
        k = 1 + SPAN + 1;
        val_s[k] = 1'b1;
        map_s[k] = 7'b0101010;
        typ_s[k] = 7'b1000001;
        add_txn(1, 1, 1'b0);
        add_txn(k, k, 1'b0);
        run_seq("queued", k + SPAN + 3);

        // Request during the done cycle is buffered, fetch follows via idle
        clear_stim();
        req_s[0] = 1'b1;
        val_s[1] = 1'b1;
        map_s[1] = 7'b0010011;
        req_s[1 + SPAN] = 1'b1;
        k = 1 + SPAN + 2;
        val_s[k] = 1'b1;
        map_s[k] = 7'b1011001;
        typ_s[k] = 7'b0100110;
        add_txn(1, 1, 1'b0);
        add_txn(k, k, 1'b0);
        run_seq("donereq", k + SPAN + 3);

        // Enable: abort in fetch, then disable mid-scroll with a pending request
        clear_stim();
        req_s[0] = 1'b1;
        for (int t = 3; t <= 5; t++) en_s[t] = 1'b0;
        req_s[4] = 1'b1;
        add_txn(1, 3, 1'b1);
        req_s[10] = 1'b1;
        val_s[11] = 1'b1;
        map_s[11] = 7'b1110001;
        typ_s[11] = 7'b0001110;
        req_s[20] = 1'b1;
        for (int t = 25; t < 60; t++) en_s[t] = 1'b0;
        req_s[30] = 1'b1;
        add_txn(11, 11, 1'b0);
        run_seq("enable", 60);

        // Reset in the middle of a scroll
        clear_stim();
        req_s[0] = 1'b1;
        val_s[1] = 1'b1;
        map_s[1] = 7'b1001001;
        typ_s[1] = 7'b0110110;
        add_txn(1, 1, 1'b0);
        run_seq("prerst", 20);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_map  = '0;
        exp_type = '0;
        exp_cnt  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_stim();
        req_s[0] = 1'b1;
        val_s[2] = 1'b1;
        map_s[2] = 7'b0111110;
        typ_s[2] = 7'b1000011;
        add_txn(1, 2, 1'b0);
        run_seq("postrst", 2 + SPAN + 3);

        // Randomized back-to-back scrolls with stray gen_valid pulses
        clear_stim();
        s = 0;
        last_k = 0;
        for (int i = 0; i < 5; i++) begin
            d = $urandom_range(0, 6);
            req_s[s] = 1'b1;
            k = s + 1 + d;
            val_s[k] = 1'b1;
            map_s[k] = 7'($urandom);
            typ_s[k] = 7'($urandom);
            add_txn(s + 1, k, 1'b0);
            d = k + 5 + $urandom_range(0, 25);
            val_s[d] = 1'b1;
            map_s[d] = 7'($urandom);
            typ_s[d] = 7'($urandom);
            last_k = k;
            s = k + SPAN + 1 + $urandom_range(0, 3);
        end
        run_seq("random", last_k + SPAN + 3);

        // Saturation of the completed-scroll counter
        @(negedge clk);
        force dut.count_q = 16'd65534;
        #1;
        release dut.count_q;
        exp_cnt = 65534;
        clear_stim();
        req_s[0] = 1'b1;
        val_s[1] = 1'b1;
        map_s[1] = 7'b1100011;
        req_s[1 + SPAN + 1] = 1'b1;
        k = 1 + SPAN + 2;
        val_s[k] = 1'b1;
        map_s[k] = 7'b0011100;
        add_txn(1, 1, 1'b0);
        add_txn(k, k, 1'b0);
        run_seq("sat", k + SPAN + 3);
        check("sat.final", 32'(scroll_count), 32'd65535);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_scroll_ctrl.md
# layer_scroll_ctrl

Sequencer for the five stacked scrolling ground layers of the play field. On a scroll request it fetches a new top row from the map generator over a valid handshake. It then broadcasts one-cycle `load` and `start` pulses to every layer instance, generates the shared 1 ms tick, and counts out the scroll window. It sits between the game-logic FSM and the layer chain, and reports completion so game logic can re-enable player input.

## Interface
Parameters:
- `CLK_HZ`, 65_000_000, pixel/system clock frequency; `TICK_DIV = CLK_HZ/1000` cycles per ms tick.
- `SCROLL_MS`, 150, ticks per scroll, equal to the layer height in pixels; legal range 1..255.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  module enable.
- `scroll_req`  in  1  one-row scroll request, level sampled per cycle.
- `gen_req`  out  1  request for a new top row from the map generator.
- `gen_valid`  in  1  generator row valid.
- `gen_map`  in  [0:6]  new row occupancy.
- `gen_type`  in  [0:6]  new row block types.
- `top_map`  out  [0:6]  registered row driven into layer 0 `layer_map_in`.
- `top_type`  out  [0:6]  registered row driven into layer 0 `block_type_in`.
- `layer_load`  out  1  broadcast load pulse.
- `layer_start`  out  1  broadcast start pulse.
- `one_ms_tick`  out  1  one-cycle tick every `TICK_DIV` cycles.
- `busy`  out  1  high in any state other than S_IDLE.
- `scroll_done`  out  1  one-cycle completion pulse.
- `req_overflow`  out  1  one-cycle pulse when a request is dropped.
- `scroll_count`  out  16  completed scrolls, saturating at 65535.

## Operation
- FSM states: S_IDLE, S_FETCH, S_LOAD, S_START, S_SCROLL, S_SETTLE, S_DONE.
- S_IDLE → S_FETCH when `scroll_req & en`, or when `pending & en`; the transition clears `pending`.
- S_FETCH:
  - `gen_req`=1.
  - On `gen_valid`, capture `gen_map`/`gen_type` into `top_map`/`top_type` and go to S_LOAD.
  - `gen_valid` in any other state is ignored.
- S_LOAD: `layer_load`=1 for exactly one cycle, then S_START.
- S_START: `layer_start`=1 for one cycle; clears the tick divider and the tick counter; then S_SCROLL.
- S_SCROLL: increment the 8-bit tick counter on each `one_ms_tick`; on the `SCROLL_MS`-th tick go to S_SETTLE.
- S_SETTLE: wait 2 cycles so the layers pass through their end state back to idle; then S_DONE.
- S_DONE:
  - `scroll_done`=1 for one cycle.
  - `scroll_count` += 1, saturating.
  - Then S_IDLE.
- Pending buffer (1 deep):
  - `scroll_req` while `busy` sets `pending`.
  - `scroll_req` while `pending` is already set pulses `req_overflow`, and the request is dropped.
- Deasserting `en`:
  - Clears `pending` and blocks new fetches.
  - An operation already past S_FETCH runs to S_DONE, so the layers stay in lockstep.
  - In S_FETCH, return to S_IDLE with `gen_req` dropped.
- The tick divider runs free whenever it is not being cleared; `en` does not gate it.

## Timing
- Reset values:
  - All outputs 0, including `top_map`/`top_type`.
  - State S_IDLE, `pending`=0, divider=0, `scroll_count`=0.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- Request-to-`gen_req` latency: 1 cycle.
- `gen_valid` sampled in cycle k: `layer_load` in cycle k+1, `layer_start` in cycle k+2.
- Ticks after start: the n-th tick occurs in cycle k+2+n·`TICK_DIV`.
- Completion: `scroll_done` occurs in cycle k+5+`SCROLL_MS`·`TICK_DIV`.
- `busy` falls the cycle after `scroll_done`. With `pending` set, `gen_req` rises in that same cycle.
- `scroll_req` in the S_DONE cycle sets `pending`; it is not dropped.
- Reset mid-scroll returns to S_IDLE immediately; the layers are reset by the same `rst_n` tree.

## Structure
- `macros.vh` gains:
  - `LAYER_W` = 7.
  - `SCROLL_MS_DEFAULT` = 150.
  - The state encodings for this block.
- One sub-module, `ms_tick_gen`: the `TICK_DIV` divider with a synchronous clear and the `one_ms_tick` output.
- The FSM, the pending flag and the counters stay in this block.

All scenarios use `CLK_HZ`=10_000 (`TICK_DIV`=10) and `SCROLL_MS`=3.

## Test plan
- Basic scroll: `scroll_req` at cycle 0, `gen_valid` held high with map 7'b1010101.
  - `gen_req` rises at cycle 1; `layer_load` at cycle 2 with `top_map`=1010101; `layer_start` at cycle 3.
  - Ticks at cycles 13, 23 and 33; `scroll_done` at cycle 36; `scroll_count`=1.
- Slow generator: `gen_valid` arrives 5 cycles after `gen_req`.
  - `gen_req` is held throughout; `layer_load` follows 1 cycle after `gen_valid`.
  - `gen_valid` pulsed during S_SCROLL leaves `top_map` unchanged.
- Queued requests: a second `scroll_req` during S_SCROLL sets `pending`.
  - `gen_req` rises in the cycle after `scroll_done`.
  - A third request while `pending` is set gives a `req_overflow` pulse, and exactly 2 scrolls complete.
- Enable: `en`=0 at S_FETCH aborts to S_IDLE.
  - `en`=0 during S_SCROLL still yields `scroll_done`, `pending` is cleared, and no further fetch occurs.
- Reset mid-scroll: `rst_n` low during S_SCROLL gives all outputs 0 asynchronously; after release a new request runs normally.
- Saturation: force `scroll_count` to 65535 and complete a scroll; the count stays 65535.
